// File: rtl/prga_fifo_param.sv
// prga_fifo_param: parametrised synchronous FIFO.
// Capacity is 2^DEPTH_LOG2 words. LOOKAHEAD selects registered (0) or
// first-word-fall-through (1) reads. An occupancy count and almost-full /
// almost-empty flags are provided.
// Optional macro PRGA_FIFO_ERR_EN builds the sticky overflow/underflow
// detectors; without it both flags are tied low.
module prga_fifo_param #(
  parameter int DATA_WIDTH         = 8,
  parameter int DEPTH_LOG2         = 3,
  parameter int LOOKAHEAD          = 0,
  parameter int ALMOST_FULL_THRES  = (1 << DEPTH_LOG2) - 2,
  parameter int ALMOST_EMPTY_THRES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  empty,
  output logic                  almost_empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0] AF_C    = PW'(ALMOST_FULL_THRES);
  localparam logic [PW-1:0] AE_C    = PW'(ALMOST_EMPTY_THRES);

  // Reject illegal configurations while elaborating.
  if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 10) begin : g_bad_depth
    $fatal(1, "prga_fifo_param: DEPTH_LOG2 must be in 1..10");
  end
  if (ALMOST_FULL_THRES < 1 || ALMOST_FULL_THRES > DEPTH) begin : g_bad_af
    $fatal(1, "prga_fifo_param: ALMOST_FULL_THRES must be in 1..DEPTH");
  end
  if (ALMOST_EMPTY_THRES < 0 || ALMOST_EMPTY_THRES > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "prga_fifo_param: ALMOST_EMPTY_THRES must be in 0..DEPTH-1");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         occ;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head;

  // Occupancy and flags come only from the registered pointers; the wrap
  // bit makes full and empty distinguishable without an extra counter.
  assign occ          = wr_ptr_q - rd_ptr_q;
  assign count        = occ;
  assign full         = (occ == DEPTH_C);
  assign empty        = (occ == '0);
  assign almost_full  = (occ >= AF_C);
  assign almost_empty = (occ <= AE_C);
  assign head         = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // Accept logic and next pointers; a full FIFO still accepts a read and an
  // empty one still accepts a write, so simultaneous requests never deadlock.
  always_comb begin
    wr_acc   = wr && !full;
    rd_acc   = rd && !empty;
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, wr_acc};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, rd_acc};
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
  end

  if (LOOKAHEAD != 0) begin : g_lookahead
    // Head word is presented directly; stale while empty.
    assign dout = head;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    // Output register loads the head word only on an accepted read.
    always_comb begin
      dout_d = dout_q;
      if (rd_acc) dout_d = head;
    end

    // Output register state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign dout = dout_q;
  end

`ifdef PRGA_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error detection; only reset clears these.
  always_comb begin
    overflow_d  = overflow_q  | (wr & full);
    underflow_d = underflow_q | (rd & empty);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_prga_fifo_param.sv
// Directed bench for prga_fifo_param: one registered-read instance (a_*)
// and one lookahead instance (b_*), sharing clock and reset.
module tb_prga_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       a_wr = 1'b0, a_rd = 1'b0;
  logic [7:0] a_din = 8'h00;
  logic       a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
  logic [7:0] a_dout;
  logic [3:0] a_count;

  logic       b_wr = 1'b0, b_rd = 1'b0;
  logic [7:0] b_din = 8'h00;
  logic       b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf;
  logic [7:0] b_dout;
  logic [3:0] b_count;

  int n_cmp = 0;
  int n_err = 0;

`ifdef PRGA_FIFO_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  prga_fifo_param #(.DATA_WIDTH(8), .DEPTH_LOG2(3), .LOOKAHEAD(0),
                    .ALMOST_FULL_THRES(6), .ALMOST_EMPTY_THRES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .full(a_full), .almost_full(a_afull),
    .wr(a_wr), .din(a_din), .empty(a_empty), .almost_empty(a_aempty),
    .rd(a_rd), .dout(a_dout), .count(a_count),
    .overflow(a_ovf), .underflow(a_unf));

  prga_fifo_param #(.DATA_WIDTH(8), .DEPTH_LOG2(3), .LOOKAHEAD(1),
                    .ALMOST_FULL_THRES(6), .ALMOST_EMPTY_THRES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .full(b_full), .almost_full(b_afull),
    .wr(b_wr), .din(b_din), .empty(b_empty), .almost_empty(b_aempty),
    .rd(b_rd), .dout(b_dout), .count(b_count),
    .overflow(b_ovf), .underflow(b_unf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] fill_v [8];
  logic [7:0] qa [$];
  logic [7:0] qb [$];
  logic [7:0] ea;

  initial begin
    fill_v[0] = 8'h5A; fill_v[1] = 8'hF6; fill_v[2] = 8'h09; fill_v[3] = 8'hC4;
    fill_v[4] = 8'h81; fill_v[5] = 8'hE2; fill_v[6] = 8'hA0; fill_v[7] = 8'h7A;

    // Power-on reset
    step(); step();
    chk("rst_count", a_count, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_full", a_full, 0);
    chk("rst_aempty", a_aempty, 1);
    chk("rst_afull", a_afull, 0);
    chk("rst_dout", a_dout, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_unf", a_unf, 0);
    rst_n = 1'b1;

    // Reset mid-run: 3 writes, one read, then async reset between edges
    for (int i = 0; i < 3; i++) begin
      a_wr = 1'b1; a_din = 8'(i + 1);
      step();
    end
    a_wr = 1'b0;
    chk("mid_count3", a_count, 3);
    a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    chk("mid_dout1", a_dout, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_count", a_count, 0);
    chk("mid_rst_empty", a_empty, 1);
    chk("mid_rst_full", a_full, 0);
    chk("mid_rst_dout", a_dout, 0);
    #1 rst_n = 1'b1;
    a_wr = 1'b1; a_din = 8'h33;
    step();
    a_wr = 1'b0;
    chk("post_rst_empty", a_empty, 0);
    chk("post_rst_count", a_count, 1);
    a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    chk("post_rst_dout", a_dout, 8'h33);
    chk("post_rst_empty2", a_empty, 1);

    // Fill 8 words, no reads
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_din = fill_v[i];
      step();
      chk("fill_count", a_count, i + 1);
      chk("fill_afull", a_afull, (i + 1) >= 6);
      chk("fill_aempty", a_aempty, (i + 1) <= 1);
      chk("fill_full", a_full, (i + 1) == 8);
    end
    a_din = 8'h11;
    step();
    a_wr = 1'b0;
    chk("ovf_count", a_count, 8);
    chk("ovf_full", a_full, 1);
    chk("ovf_flag", a_ovf, ERR_EXP);

    // Registered-read drain, rd held high
    a_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("drain_dout", a_dout, fill_v[i]);
      chk("drain_count", a_count, 7 - i);
    end
    chk("drain_empty", a_empty, 1);
    step();
    a_rd = 1'b0;
    chk("unf_flag", a_unf, ERR_EXP);
    chk("unf_dout_hold", a_dout, 8'h7A);
    chk("unf_count", a_count, 0);

    // Simultaneous read/write at count 4
    for (int i = 0; i < 4; i++) begin
      a_wr = 1'b1; a_din = 8'h10 + 8'(i);
      step();
    end
    a_rd = 1'b1; a_din = 8'h14;
    step();
    chk("rw4_count", a_count, 4);
    chk("rw4_dout0", a_dout, 8'h10);
    a_din = 8'h15;
    step();
    a_wr = 1'b0;
    chk("rw4_count2", a_count, 4);
    chk("rw4_dout1", a_dout, 8'h11);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rw4_order", a_dout, 8'h12 + 8'(i));
    end
    a_rd = 1'b0;
    chk("rw4_empty", a_empty, 1);

    // Simultaneous read/write at full
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_din = 8'h20 + 8'(i);
      step();
    end
    chk("rwf_full", a_full, 1);
    a_rd = 1'b1; a_din = 8'hEE;
    step();
    a_wr = 1'b0;
    chk("rwf_count", a_count, 7);
    chk("rwf_dout", a_dout, 8'h20);
    for (int i = 1; i < 8; i++) begin
      step();
      chk("rwf_order", a_dout, 8'h20 + 8'(i));
    end
    a_rd = 1'b0;
    chk("rwf_lost", a_empty, 1);

    // Simultaneous read/write at empty
    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h44;
    step();
    a_wr = 1'b0; a_rd = 1'b0;
    chk("rwe_count", a_count, 1);
    chk("rwe_dout_hold", a_dout, 8'h27);
    chk("rwe_empty", a_empty, 0);
    a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    chk("rwe_dout", a_dout, 8'h44);

    // Lookahead single word
    chk("la_empty0", b_empty, 1);
    b_wr = 1'b1; b_din = 8'hA5;
    step();
    b_wr = 1'b0;
    chk("la_empty", b_empty, 0);
    chk("la_dout", b_dout, 8'hA5);
    chk("la_count", b_count, 1);
    b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    chk("la_pop_empty", b_empty, 1);
    chk("la_pop_count", b_count, 0);

    // Random traffic on both instances against queue models
    for (int c = 0; c < 1000; c++) begin
      logic wa, ra, wb, rb;
      a_wr = 1'($urandom_range(0, 1)); a_rd = 1'($urandom_range(0, 1));
      b_wr = 1'($urandom_range(0, 1)); b_rd = 1'($urandom_range(0, 1));
      a_din = 8'($urandom); b_din = 8'($urandom);
      wa = a_wr && (qa.size() < 8);
      ra = a_rd && (qa.size() > 0);
      wb = b_wr && (qb.size() < 8);
      rb = b_rd && (qb.size() > 0);
      step();
      if (ra) begin
        ea = qa.pop_front();
        chk("rnd_a_dout", a_dout, ea);
      end
      if (rb) void'(qb.pop_front());
      if (wa) qa.push_back(a_din);
      if (wb) qb.push_back(b_din);
      chk("rnd_a_count", a_count, qa.size());
      chk("rnd_b_count", b_count, qb.size());
      if (qb.size() > 0) chk("rnd_b_dout", b_dout, qb[0]);
    end
    a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
